// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter that time-shares one external
// combinational add/sub ALU between four requesters. Each grant runs a
// fixed three-cycle transaction: latch operands, let the ALU settle and
// capture its result, then pulse ready to the granted requester.
module addsub_arbiter #(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [3:0]     req_i,
  input  logic [3:0]     mode_i,
  input  logic [4*W-1:0] a_i,
  input  logic [4*W-1:0] b_i,
  input  logic [W-1:0]   alu_res_i,
  output logic           alu_mode_o,
  output logic [W-1:0]   alu_a_o,
  output logic [W-1:0]   alu_b_o,
  output logic [3:0]     ready_o,
  output logic [W-1:0]   res_o,
  output logic [1:0]     gnt_id_o,
  output logic           busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e         state_q;
  logic [1:0]     ptr_q;
  logic [1:0]     gnt_q;
  logic           mode_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic [3:0]     ready_q;

  logic           winValid_d;
  logic [1:0]     winIdx_d;
  logic [1:0]     cand;

  // Round-robin pick: scan ptr+1 .. ptr+4 (mod 4) and take the first active request.
  always_comb begin
    winValid_d = 1'b0;
    winIdx_d   = ptr_q;
    cand       = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!winValid_d && req_i[cand]) begin
        winValid_d = 1'b1;
        winIdx_d   = cand;
      end
    end
  end

  // Transaction sequencer; operand, result and grant registers hold between transactions.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      gnt_q   <= '0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ready_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= '0;
          if (winValid_d) begin
            gnt_q   <= winIdx_d;
            mode_q  <= mode_i[winIdx_d];
            a_q     <= a_i[W*winIdx_d +: W];
            b_q     <= b_i[W*winIdx_d +: W];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          res_q   <= alu_res_i;
          ready_q <= 4'b0001 << gnt_q;
          state_q <= RESP;
        end
        RESP: begin
          ready_q <= '0;
          ptr_q   <= gnt_q;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_mode_o = mode_q;
  assign alu_a_o    = a_q;
  assign alu_b_o    = b_q;
  assign res_o      = res_q;
  assign ready_o    = ready_q;
  assign gnt_id_o   = gnt_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: self-checking bench for addsub_arbiter with a
// behavioural ALU attached and a transaction-level reference model.
module tb_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  req;
  logic [3:0]  mode;
  logic [31:0] aBus;
  logic [31:0] bBus;
  logic [7:0]  aluRes;
  logic        aluMode;
  logic [7:0]  aluA;
  logic [7:0]  aluB;
  logic [3:0]  ready;
  logic [7:0]  res;
  logic [1:0]  gntId;
  logic        busy;

  int nCompared   = 0;
  int nMismatched = 0;
  int lastServed  = 3;

  always #5 clk = ~clk;

  // External ALU: wrap-around add or subtract of the presented operands.
  assign aluRes = aluMode ? (aluA + aluB) : (aluA - aluB);

  addsub_arbiter #(.W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rstN),
    .req_i      (req),
    .mode_i     (mode),
    .a_i        (aBus),
    .b_i        (bBus),
    .alu_res_i  (aluRes),
    .alu_mode_o (aluMode),
    .alu_a_o    (aluA),
    .alu_b_o    (aluB),
    .ready_o    (ready),
    .res_o      (res),
    .gnt_id_o   (gntId),
    .busy_o     (busy)
  );

  // Round-robin reference: first requester after the last-served one, cyclically.
  function automatic int pickWinner(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] expResult(input logic m, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    s = m ? (a + b) : (a - b);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic m, input logic [7:0] a, input logic [7:0] b);
    mode[k]        = m;
    aBus[8*k +: 8] = a;
    bBus[8*k +: 8] = b;
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    req  = '0;
    tick();
    tick();
    @(negedge clk);
    rstN = 1'b1;
    lastServed = 3;
  endtask

  task automatic test_reset();
    applyReset();
    nCompared++; if (ready !== 4'b0) begin nMismatched++; $display("[TB] FAIL rst_ready: got %b want 0000", ready); end
    nCompared++; if (res !== 8'd0) begin nMismatched++; $display("[TB] FAIL rst_res: got %0d want 0", res); end
    nCompared++; if ({aluMode, aluA, aluB} !== 17'd0) begin nMismatched++; $display("[TB] FAIL rst_alu: got %b/%0d/%0d want 0/0/0", aluMode, aluA, aluB); end
    nCompared++; if (gntId !== 2'd0) begin nMismatched++; $display("[TB] FAIL rst_gnt: got %0d want 0", gntId); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_add();
    applyStimulus(0, 1'b1, 8'd5, 8'd3);
    req = 4'b0001;
    tick();
    nCompared++; if (aluA !== 8'd5 || aluB !== 8'd3 || aluMode !== 1'b1) begin nMismatched++; $display("[TB] FAIL add_alu: got %b/%0d/%0d want 1/5/3", aluMode, aluA, aluB); end
    nCompared++; if (busy !== 1'b1 || ready !== 4'b0) begin nMismatched++; $display("[TB] FAIL add_issue: got busy=%b ready=%b want 1/0000", busy, ready); end
    tick();
    nCompared++; if (ready !== 4'b0001 || res !== 8'd8) begin nMismatched++; $display("[TB] FAIL add_resp: got ready=%b res=%0d want 0001/8", ready, res); end
    tick();
    req = 4'b0000;
    lastServed = 0;
    nCompared++; if (busy !== 1'b0 || ready !== 4'b0) begin nMismatched++; $display("[TB] FAIL add_done: got busy=%b ready=%b want 0/0000", busy, ready); end
  endtask

  task automatic test_sub_wrap();
    applyStimulus(2, 1'b0, 8'd3, 8'd5);
    req = 4'b0100;
    tick();
    nCompared++; if (gntId !== 2'd2) begin nMismatched++; $display("[TB] FAIL sub_gnt: got %0d want 2", gntId); end
    tick();
    nCompared++; if (ready !== 4'b0100 || res !== 8'd254) begin nMismatched++; $display("[TB] FAIL sub_resp: got ready=%b res=%0d want 0100/254", ready, res); end
    tick();
    req = 4'b0000;
    lastServed = 2;
  endtask

  task automatic test_all_four();
    applyReset();
    for (int k = 0; k < 4; k++) applyStimulus(k, 1'b1, 8'(k), 8'd10);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = pickWinner(req, lastServed);
      tick();
      nCompared++; if (int'(gntId) !== w || w !== i) begin nMismatched++; $display("[TB] FAIL all4_gnt%0d: got %0d want %0d", i, gntId, i); end
      tick();
      nCompared++; if (ready !== (4'b0001 << i) || res !== 8'(10 + i)) begin nMismatched++; $display("[TB] FAIL all4_resp%0d: got ready=%b res=%0d want %b/%0d", i, ready, res, 4'b0001 << i, 10 + i); end
      tick();
      req[i] = 1'b0;
      lastServed = i;
    end
    tick();
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL all4_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_fairness();
    int served1 = 0;
    int waited  = 0;
    req = 4'b0101;
    for (int op = 0; op < 10; op++) begin
      int w;
      logic [7:0] ea, eb;
      logic em;
      if (op == 3) begin
        applyStimulus(1, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        req[1] = 1'b1;
      end
      if (req[1]) waited++;
      applyStimulus(0, 1'($urandom), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      applyStimulus(2, 1'($urandom), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      w  = pickWinner(req, lastServed);
      em = mode[w];
      ea = aBus[8*w +: 8];
      eb = bBus[8*w +: 8];
      tick();
      nCompared++; if (int'(gntId) !== w) begin nMismatched++; $display("[TB] FAIL fair_gnt op%0d: got %0d want %0d", op, gntId, w); end
      tick();
      nCompared++; if (ready !== (4'b0001 << w) || res !== expResult(em, ea, eb)) begin nMismatched++; $display("[TB] FAIL fair_resp op%0d: got ready=%b res=%0d want %b/%0d", op, ready, res, 4'b0001 << w, expResult(em, ea, eb)); end
      tick();
      lastServed = w;
      if (w == 1) begin
        served1 = 1;
        req[1]  = 1'b0;
        nCompared++; if (waited > 4) begin nMismatched++; $display("[TB] FAIL fair_latency: got %0d transactions want <= 4", waited); end
      end
    end
    req = 4'b0000;
    nCompared++; if (served1 !== 1) begin nMismatched++; $display("[TB] FAIL fair_served1: got %0d want 1", served1); end
  endtask

  task automatic test_idle_hold();
    applyStimulus(1, 1'b1, 8'd40, 8'd2);
    req = 4'b0010;
    tick();
    tick();
    tick();
    req = 4'b0000;
    lastServed = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      nCompared++; if (busy !== 1'b0 || ready !== 4'b0 || res !== 8'd42 || aluA !== 8'd40 || aluB !== 8'd2 || aluMode !== 1'b1 || gntId !== 2'd1) begin
        nMismatched++; $display("[TB] FAIL idle_hold c%0d: got busy=%b ready=%b res=%0d alu=%b/%0d/%0d gnt=%0d want 0/0000/42/1/40/2/1", c, busy, ready, res, aluMode, aluA, aluB, gntId);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] heldRes = 8'd42;
    for (int t = 0; t < 40; t++) begin
      int w;
      logic [7:0] ea, eb;
      logic em;
      req  = 4'($urandom);
      mode = 4'($urandom);
      aBus = $urandom;
      bBus = $urandom;
      w = pickWinner(req, lastServed);
      if (w < 0) begin
        tick();
        nCompared++; if (busy !== 1'b0 || ready !== 4'b0 || res !== heldRes) begin nMismatched++; $display("[TB] FAIL rand_idle t%0d: got busy=%b ready=%b res=%0d want 0/0000/%0d", t, busy, ready, res, heldRes); end
      end else begin
        em = mode[w];
        ea = aBus[8*w +: 8];
        eb = bBus[8*w +: 8];
        tick();
        nCompared++; if (int'(gntId) !== w || aluA !== ea || aluB !== eb || aluMode !== em || busy !== 1'b1) begin
          nMismatched++; $display("[TB] FAIL rand_issue t%0d: got gnt=%0d alu=%b/%0d/%0d want %0d/%b/%0d/%0d", t, gntId, aluMode, aluA, aluB, w, em, ea, eb);
        end
        tick();
        heldRes = expResult(em, ea, eb);
        nCompared++; if (ready !== (4'b0001 << w) || res !== heldRes) begin nMismatched++; $display("[TB] FAIL rand_resp t%0d: got ready=%b res=%0d want %b/%0d", t, ready, res, 4'b0001 << w, heldRes); end
        tick();
        lastServed = w;
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    applyStimulus(3, 1'b1, 8'hFF, 8'h01);
    req = 4'b1000;
    tick();
    nCompared++; if (gntId !== 2'd3 || busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid_gnt: got gnt=%0d busy=%b want 3/1", gntId, busy); end
    #2;
    rstN = 1'b0;
    #1;
    nCompared++; if (busy !== 1'b0 || ready !== 4'b0 || res !== 8'd0 || aluA !== 8'd0 || aluB !== 8'd0 || aluMode !== 1'b0 || gntId !== 2'd0) begin
      nMismatched++; $display("[TB] FAIL rmid_clear: got busy=%b ready=%b res=%0d alu=%b/%0d/%0d gnt=%0d want all 0", busy, ready, res, aluMode, aluA, aluB, gntId);
    end
    tick();
    nCompared++; if (ready !== 4'b0) begin nMismatched++; $display("[TB] FAIL rmid_noready: got %b want 0000", ready); end
    @(negedge clk);
    rstN = 1'b1;
    lastServed = 3;
    applyStimulus(1, 1'b1, 8'd20, 8'd7);
    req = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      int w;
      logic [7:0] er;
      w  = pickWinner(req, lastServed);
      er = expResult(mode[w], aBus[8*w +: 8], bBus[8*w +: 8]);
      tick();
      nCompared++; if (int'(gntId) !== w || w !== (i == 0 ? 1 : 3)) begin nMismatched++; $display("[TB] FAIL rmid_order%0d: got %0d want %0d", i, gntId, i == 0 ? 1 : 3); end
      tick();
      nCompared++; if (ready !== (4'b0001 << w) || res !== er) begin nMismatched++; $display("[TB] FAIL rmid_resp%0d: got ready=%b res=%0d want %b/%0d", i, ready, res, 4'b0001 << w, er); end
      tick();
      req[w] = 1'b0;
      lastServed = w;
    end
  endtask

  initial begin
    rstN = 1'b0;
    req  = '0;
    mode = '0;
    aBus = '0;
    bBus = '0;
    test_reset();
    test_single_add();
    test_sub_wrap();
    test_all_four();
    test_fairness();
    test_idle_hold();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
